// File: rtl/glitc_dp_pkg.sv
// -----------------------------------------------------------------------------
// glitc_dp_pkg
//   Shared constants, types and bit-order slice helpers for the GLITC
//   per-channel datapath aligner.
//   Bit-order layout: word[NSAMP*b +: NSAMP] is line b, LSB = earliest sample.
//   Delay layout:     dly[DLY_W*b +: DLY_W]  is the delay of line b.
// -----------------------------------------------------------------------------
package glitc_dp_pkg;

    localparam int unsigned NBITS     = 12;
    localparam int unsigned NSAMP     = 4;
    localparam int unsigned DLY_W     = 3;
    localparam int unsigned CNT_W     = 8;
    localparam logic [7:0]  TRAIN_PAT = 8'hB4;
    localparam int unsigned CHECK_LEN = 256;
    localparam int unsigned LOCK_TO   = 16;

    localparam int unsigned WORD_W = NBITS * NSAMP;
    localparam int unsigned DLYV_W = NBITS * DLY_W;
    localparam int unsigned ERR_W  = NBITS * CNT_W;

    typedef logic [NSAMP-1:0] samp_t;
    typedef logic [DLY_W-1:0] dly_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StCheck,
        StDone
    } state_e;

    // Samples of line b from a bit-order word.
    function automatic samp_t line_of(input logic [WORD_W-1:0] w, input int unsigned b);
        return w[NSAMP*b +: NSAMP];
    endfunction

    // Delay select of line b from the packed delay vector.
    function automatic dly_t dly_of(input logic [DLYV_W-1:0] d, input int unsigned b);
        return d[DLY_W*b +: DLY_W];
    endfunction

    // Saturating increment for the per-line error counters.
    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/glitc_datapath_aligner_if.sv
// -----------------------------------------------------------------------------
// glitc_datapath_aligner_if
//   Bundles the aligner's data/control signals.
//   slave  : the aligner (consumes valid_i/dat_i/dly_i/train_i, drives the rest)
//   master : the producer / monitor side
//   Signals:
//     valid_i     word valid from the datapath buffer
//     dat_i       48-bit bit-order input word
//     dly_i       36-bit per-line delay selects
//     train_i     one-cycle pulse starting (or restarting) a check run
//     valid_o     dat_o valid
//     dat_o       48-bit aligned word
//     busy_o      check run in progress
//     done_o      last run finished
//     lock_fail_o last run never found the pattern phase
//     err_o       96-bit packed per-line error counters
// -----------------------------------------------------------------------------
interface glitc_datapath_aligner_if;
    import glitc_dp_pkg::*;

    logic              valid_i;
    logic [WORD_W-1:0] dat_i;
    logic [DLYV_W-1:0] dly_i;
    logic              train_i;
    logic              valid_o;
    logic [WORD_W-1:0] dat_o;
    logic              busy_o;
    logic              done_o;
    logic              lock_fail_o;
    logic [ERR_W-1:0]  err_o;

    modport slave (
        input  valid_i, dat_i, dly_i, train_i,
        output valid_o, dat_o, busy_o, done_o, lock_fail_o, err_o
    );

    modport master (
        output valid_i, dat_i, dly_i, train_i,
        input  valid_o, dat_o, busy_o, done_o, lock_fail_o, err_o
    );

endinterface

// File: rtl/glitc_line_delay.sv
// -----------------------------------------------------------------------------
// glitc_line_delay
//   One bit line: keeps the two previous valid words and selects a 4-sample
//   window delayed by 0..7 samples, registered on each valid word.
//   Ports:
//     clk      system clock
//     rst      synchronous active-high reset (clears history and output)
//     valid    current word valid; history and output only move when high
//     cur      current word of this line (bit 0 = earliest sample)
//     dly      delay in samples
//     aligned  registered delayed word
// -----------------------------------------------------------------------------
module glitc_line_delay
    import glitc_dp_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  valid,
    input  samp_t cur,
    input  dly_t  dly,
    output samp_t aligned
);

    localparam int unsigned HIST_W = 3 * NSAMP;

    samp_t             prev_q;
    samp_t             prev2_q;
    samp_t             aligned_q;
    logic [HIST_W-1:0] hist;
    logic [3:0]        shamt;
    samp_t             slice;

    // hist = {cur, prev, prev2}; hist[0] is the oldest sample held.
    // The window hist[11-d -: 4] starts at bit 8-d.
    always_comb begin
        hist  = {cur, prev_q, prev2_q};
        shamt = 4'(2 * NSAMP) - {1'b0, dly};
        slice = samp_t'(hist >> shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            prev2_q   <= '0;
            aligned_q <= '0;
        end else if (valid) begin
            prev2_q   <= prev_q;
            prev_q    <= cur;
            aligned_q <= slice;
        end
    end

    assign aligned = aligned_q;

endmodule

// File: rtl/glitc_datapath_aligner.sv
// -----------------------------------------------------------------------------
// glitc_datapath_aligner
//   Per-channel sample-stream aligner. Each of the 12 bit lines is delayed by
//   a programmable 0..7 samples (latency 1 SYSCLK), and a training-pattern
//   checker counts per-line mismatches on the aligned words.
//   Ports:
//     SYSCLK  system clock, all logic on posedge
//     rst_i   synchronous active-high reset
//     bus     glitc_datapath_aligner_if.slave (data, delays, train, status)
//   Checker: IDLE -> (train) ARM -> (line 0 matches a pattern half) CHECK
//            -> (CHECK_LEN words) DONE; ARM times out to DONE after LOCK_TO
//            words with lock_fail set. train_i restarts from any state.
// -----------------------------------------------------------------------------
module glitc_datapath_aligner
    import glitc_dp_pkg::*;
(
    input logic                     SYSCLK,
    input logic                     rst_i,
    glitc_datapath_aligner_if.slave bus
);

    localparam int unsigned       LEN_W     = $clog2(CHECK_LEN);
    localparam int unsigned       LOCK_W    = $clog2(LOCK_TO);
    localparam logic [LEN_W-1:0]  LEN_LAST  = LEN_W'(CHECK_LEN - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TO - 1);
    localparam samp_t             PAT_LO    = TRAIN_PAT[NSAMP-1:0];
    localparam samp_t             PAT_HI    = TRAIN_PAT[2*NSAMP-1:NSAMP];

    // ---------------------------------------------------------------------
    // Delay lines
    // ---------------------------------------------------------------------
    samp_t [NBITS-1:0] line_out;
    logic              valid_q;

    for (genvar b = 0; b < NBITS; b++) begin : g_line
        glitc_line_delay u_line (
            .clk     (SYSCLK),
            .rst     (rst_i),
            .valid   (bus.valid_i),
            .cur     (line_of(bus.dat_i, b)),
            .dly     (dly_of(bus.dly_i, b)),
            .aligned (line_out[b])
        );
    end

    always_ff @(posedge SYSCLK) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.valid_i;
        end
    end

    // ---------------------------------------------------------------------
    // Checker state and counters
    // ---------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
    logic               phase_q, phase_d;
    logic               lock_fail_q, lock_fail_d;
    cnt_t [NBITS-1:0]   err_q, err_d;

    logic               hit_lo;
    logic               hit_hi;
    samp_t              exp_nib;

    // Line 0 alone decides the pattern phase; phase=1 means the next word
    // should carry the high half.
    assign hit_lo  = (line_out[0] == PAT_LO);
    assign hit_hi  = (line_out[0] == PAT_HI);
    assign exp_nib = phase_q ? PAT_HI : PAT_LO;

    // State register
    always_ff @(posedge SYSCLK) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; train_i wins over a same-cycle timeout or end of run.
    always_comb begin
        state_d = state_q;
        if (bus.train_i) begin
            state_d = StArm;
        end else if (valid_q) begin
            unique case (state_q)
                StArm: begin
                    if (hit_lo || hit_hi) begin
                        state_d = StCheck;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_d = StDone;
                    end
                end
                StCheck: begin
                    if (len_cnt_q == LEN_LAST) begin
                        state_d = StDone;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Counter / flag next values
    always_comb begin
        lock_cnt_d  = lock_cnt_q;
        len_cnt_d   = len_cnt_q;
        phase_d     = phase_q;
        lock_fail_d = lock_fail_q;
        err_d       = err_q;
        if (bus.train_i) begin
            lock_cnt_d  = '0;
            len_cnt_d   = '0;
            phase_d     = 1'b0;
            lock_fail_d = 1'b0;
            err_d       = '0;
        end else if (valid_q) begin
            unique case (state_q)
                StArm: begin
                    if (hit_lo) begin
                        phase_d = 1'b1;
                    end else if (hit_hi) begin
                        phase_d = 1'b0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                        if (lock_cnt_q == LOCK_LAST) begin
                            lock_fail_d = 1'b1;
                        end
                    end
                end
                StCheck: begin
                    phase_d   = ~phase_q;
                    len_cnt_d = len_cnt_q + 1'b1;
                    for (int unsigned b = 0; b < NBITS; b++) begin
                        if (line_out[b] != exp_nib) begin
                            err_d[b] = sat_inc(err_q[b]);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (rst_i) begin
            lock_cnt_q  <= '0;
            len_cnt_q   <= '0;
            phase_q     <= 1'b0;
            lock_fail_q <= 1'b0;
            err_q       <= '0;
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            len_cnt_q   <= len_cnt_d;
            phase_q     <= phase_d;
            lock_fail_q <= lock_fail_d;
            err_q       <= err_d;
        end
    end

    // Outputs
    always_comb begin
        bus.valid_o     = valid_q;
        bus.dat_o       = line_out;
        bus.busy_o      = (state_q == StArm) || (state_q == StCheck);
        bus.done_o      = (state_q == StDone);
        bus.lock_fail_o = lock_fail_q;
        bus.err_o       = err_q;
    end

endmodule

// File: tb/tb_glitc_datapath_aligner.sv
module tb_glitc_datapath_aligner;
    import glitc_dp_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    glitc_datapath_aligner_if bus ();

    glitc_datapath_aligner dut (
        .SYSCLK (clk),
        .rst_i  (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int wk    = 0;

    typedef struct {
        logic        vin;
        logic [43:0] up;
        logic [3:0]  nib;
        logic [2:0]  d;
        logic        vexp;
        logic [3:0]  nexp;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, want %0b", nm, act, exp);
        end
    endtask

    // Drive at a negedge, advance one full cycle to the next negedge.
    task automatic cyc(input logic v, input logic [47:0] w, input logic tr);
        bus.valid_i = v;
        bus.dat_i   = w;
        bus.train_i = tr;
        @(negedge clk);
    endtask

    // Word k of the training stream; line 3 advanced by adv3 samples.
    function automatic logic [47:0] pword(input int k, input int adv3);
        logic [7:0]  p;
        logic [47:0] w;
        p = TRAIN_PAT;
        w = '0;
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < 4; i++) begin
                w[4*b+i] = p[3'((4*k + i + ((b == 3) ? adv3 : 0)) % 8)];
            end
        end
        return w;
    endfunction

    task automatic send_pat(input int n, input int adv3, input int f_lo, input int f_hi);
        logic [47:0] w;
        for (int i = 0; i < n; i++) begin
            w = pword(wk, adv3);
            if (i >= f_lo && i < f_hi) w[28] = ~w[28];
            cyc(1'b1, w, 1'b0);
            wk++;
        end
    endtask

    function automatic logic [95:0] err1(input int b, input int v);
        return 96'(v) << (8 * b);
    endfunction

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.dat_i   = '0;
        bus.dly_i   = '0;
        bus.train_i = 1'b0;

        // vin, upper 44 bits, line0 nibble, line0 delay, expected valid, expected line0
        tv[0]  = '{1'b1, 44'h0123456789A, 4'h1, 3'd0, 1'b1, 4'h1};
        tv[1]  = '{1'b1, 44'hFEDCBA98765, 4'h2, 3'd0, 1'b1, 4'h2};
        tv[2]  = '{1'b0, 44'h55555555555, 4'hF, 3'd0, 1'b0, 4'h0};
        tv[3]  = '{1'b1, 44'hAAAAAAAAAAA, 4'h3, 3'd0, 1'b1, 4'h3};
        tv[4]  = '{1'b1, 44'h13579BDF024, 4'hF, 3'd5, 1'b1, 4'h6};
        tv[5]  = '{1'b0, 44'h77777777777, 4'h5, 3'd5, 1'b0, 4'h0};
        tv[6]  = '{1'b1, 44'h2468ACE1357, 4'hC, 3'd5, 1'b1, 4'hE};
        tv[7]  = '{1'b1, 44'h0F0F0F0F0F0, 4'h0, 3'd5, 1'b1, 4'h9};
        tv[8]  = '{1'b1, 44'h00000000001, 4'h5, 3'd7, 1'b1, 4'h6};
        tv[9]  = '{1'b1, 44'hFFFFFFFFFFF, 4'hA, 3'd4, 1'b1, 4'h5};
        tv[10] = '{1'b1, 44'h84218421842, 4'h9, 3'd0, 1'b1, 4'h9};

        @(negedge clk);
        cyc(1'b0, 48'h0, 1'b0);
        cyc(1'b0, 48'h0, 1'b0);

        // 1: reset state, ARM without data, lock timeout
        chk1("rst valid_o", bus.valid_o, 1'b0);
        chk("rst dat_o", 96'(bus.dat_o), 96'h0);
        chk1("rst busy_o", bus.busy_o, 1'b0);
        chk1("rst done_o", bus.done_o, 1'b0);
        chk1("rst lock_fail_o", bus.lock_fail_o, 1'b0);
        chk("rst err_o", bus.err_o, 96'h0);
        rst = 1'b0;
        cyc(1'b0, 48'h0, 1'b1);
        chk1("arm busy_o", bus.busy_o, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 48'h0, 1'b0);
        chk1("arm hold busy_o", bus.busy_o, 1'b1);
        chk1("arm hold done_o", bus.done_o, 1'b0);
        chk("arm hold err_o", bus.err_o, 96'h0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 48'h0, 1'b0);
        chk1("lock 15 done_o", bus.done_o, 1'b0);
        cyc(1'b0, 48'h0, 1'b0);
        chk1("lock to done_o", bus.done_o, 1'b1);
        chk1("lock to lock_fail_o", bus.lock_fail_o, 1'b1);
        chk1("lock to busy_o", bus.busy_o, 1'b0);

        // 2: delay table with valid gaps
        rst = 1'b1;
        cyc(1'b0, 48'h0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus.dly_i = {33'h0, tv[i].d};
            cyc(tv[i].vin, {tv[i].up, tv[i].nib}, 1'b0);
            chk1($sformatf("vec%0d valid_o", i), bus.valid_o, tv[i].vexp);
            if (tv[i].vexp) begin
                chk($sformatf("vec%0d dat_o", i), 96'(bus.dat_o), 96'({tv[i].up, tv[i].nexp}));
            end
        end
        bus.dly_i = '0;

        // 3: clean pattern, full run boundary
        send_pat(4, 0, -1, -1);
        cyc(1'b0, 48'h0, 1'b1);
        chk1("clean busy after train", bus.busy_o, 1'b1);
        send_pat(257, 0, -1, -1);
        chk1("clean 255 chk done_o", bus.done_o, 1'b0);
        chk1("clean 255 chk busy_o", bus.busy_o, 1'b1);
        send_pat(1, 0, -1, -1);
        chk1("clean done_o", bus.done_o, 1'b1);
        chk1("clean lock_fail_o", bus.lock_fail_o, 1'b0);
        chk1("clean busy_o", bus.busy_o, 1'b0);
        chk("clean err_o", bus.err_o, 96'h0);

        // 4: line 3 advanced 2 samples, compensated then not
        bus.dly_i = 36'(2) << 9;
        send_pat(4, 2, -1, -1);
        cyc(1'b0, 48'h0, 1'b1);
        send_pat(258, 2, -1, -1);
        chk1("skew comp done_o", bus.done_o, 1'b1);
        chk("skew comp err_o", bus.err_o, 96'h0);
        bus.dly_i = '0;
        send_pat(4, 2, -1, -1);
        cyc(1'b0, 48'h0, 1'b1);
        chk("skew train clears err_o", bus.err_o, 96'h0);
        send_pat(256, 2, -1, -1);
        chk("skew err 254", bus.err_o, err1(3, 254));
        send_pat(1, 2, -1, -1);
        chk("skew err 255", bus.err_o, err1(3, 255));
        chk1("skew 255 done_o", bus.done_o, 1'b0);
        send_pat(1, 2, -1, -1);
        chk1("skew sat done_o", bus.done_o, 1'b1);
        chk("skew sat err_o", bus.err_o, err1(3, 255));

        // 5: ten flipped words on line 7
        send_pat(4, 0, -1, -1);
        cyc(1'b0, 48'h0, 1'b1);
        send_pat(258, 0, 20, 30);
        chk1("flip done_o", bus.done_o, 1'b1);
        chk("flip err_o", bus.err_o, err1(7, 10));

        // 6: restart mid-CHECK, then reset mid-run
        send_pat(4, 2, -1, -1);
        cyc(1'b0, 48'h0, 1'b1);
        send_pat(50, 2, -1, -1);
        chk("mid err 48", bus.err_o, err1(3, 48));
        cyc(1'b0, 48'h0, 1'b1);
        chk("retrain err_o", bus.err_o, 96'h0);
        chk1("retrain busy_o", bus.busy_o, 1'b1);
        chk1("retrain done_o", bus.done_o, 1'b0);
        send_pat(10, 2, -1, -1);
        chk("retrain err 8", bus.err_o, err1(3, 8));
        rst = 1'b1;
        cyc(1'b1, pword(wk, 2), 1'b0);
        chk1("midrst valid_o", bus.valid_o, 1'b0);
        chk("midrst dat_o", 96'(bus.dat_o), 96'h0);
        chk1("midrst busy_o", bus.busy_o, 1'b0);
        chk1("midrst done_o", bus.done_o, 1'b0);
        chk1("midrst lock_fail_o", bus.lock_fail_o, 1'b0);
        chk("midrst err_o", bus.err_o, 96'h0);
        rst = 1'b0;
        cyc(1'b0, 48'h0, 1'b0);
        cyc(1'b0, 48'h0, 1'b0);
        chk1("post rst idle busy_o", bus.busy_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
